pipeline_ctrl: RTL

Central sequencer for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB). Each cycle it produces the per-latch enable and flush strobes from cache handshakes, load-use hazards, taken control transfers and halt. It also drains the pipeline on halt and keeps a saturating stall-cycle counter for performance runs. It sits beside the datapath, and its outputs drive the enables of the existing latch blocks (decode_en, etc.).

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/hazard_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline latch sequencer: FSM states and the bundle of
// per-cycle enable/flush strobes, plus the canned strobe patterns it emits.
package pipe_ctrl_pkg;

    localparam int REG_W_DEF = 5;

    typedef logic [REG_W_DEF-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic fetch_en;
        logic decode_en;
        logic exec_en;
        logic mem_en;
        logic fetch_flush;
        logic decode_flush;
    } ctrl_t;

    // Field order: pc, fetch, decode, exec, mem, fetch_flush, decode_flush
    localparam ctrl_t CTRL_HOLD    = 7'b000_0000;
    localparam ctrl_t CTRL_RUN     = 7'b111_1100;
    localparam ctrl_t CTRL_BRANCH  = 7'b111_1111;
    localparam ctrl_t CTRL_SQUASH  = 7'b011_1111;
    localparam ctrl_t CTRL_LOADUSE = 7'b001_1101;
    localparam ctrl_t CTRL_FMISS   = 7'b011_1110;

    // A cycle is a stall cycle when the PC holds or any bubble is inserted.
    function automatic logic is_stall(input ctrl_t c);
        return !c.pc_en || c.fetch_flush || c.decode_flush;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the instruction in IF/ID.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_wsel,
    output logic             hazard
);

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign hazard = ex_dREN && (ex_wsel != '0) &&
                    ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline latch sequencer: per-latch enables/flushes, halt drain and a
// saturating stall-cycle counter.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int HALT_DRAIN = 2,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_wsel,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             branch_taken,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             fetch_flush,
    output logic             decode_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] DRAIN_LOAD = 4'(HALT_DRAIN - 1);

    state_t           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic             halt_q;
    logic [CNT_W-1:0] stall_q;

    logic  hazard;
    logic  mem_stall;
    ctrl_t run_ctrl;
    ctrl_t ctrl;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_dREN    (ex_dREN),
        .ex_wsel    (ex_wsel),
        .hazard     (hazard)
    );

    assign mem_stall = (mem_dREN || mem_dWEN) && !dhit;

    // Branch outranks load-use: the dependent instruction is being squashed anyway.
    always_comb begin
        if (branch_taken)
            run_ctrl = CTRL_BRANCH;
        else if (hazard)
            run_ctrl = CTRL_LOADUSE;
        else if (!ihit)
            run_ctrl = CTRL_FMISS;
        else
            run_ctrl = CTRL_RUN;
    end

    always_comb begin
        ctrl    = CTRL_HOLD;
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEMWAIT;
                end else if (mem_halt) begin
                    ctrl    = CTRL_SQUASH;
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    ctrl = run_ctrl;
                end
            end
            MEMWAIT: begin
                if (dhit) begin
                    ctrl    = run_ctrl;
                    state_d = RUN;
                end
            end
            DRAIN: begin
                ctrl    = CTRL_SQUASH;
                drain_d = (drain_q == 4'd0) ? 4'd0 : drain_q - 4'd1;
                if (drain_q <= 4'd1)
                    state_d = HALTED;
            end
            HALTED: begin
                ctrl = CTRL_HOLD;
            end
        endcase
        if (!nRST)
            ctrl = CTRL_HOLD;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            drain_q <= 4'd0;
            halt_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (state_d == HALTED)
                halt_q <= 1'b1;
            if ((state_q == RUN || state_q == MEMWAIT) && is_stall(ctrl) && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign fetch_en     = ctrl.fetch_en;
    assign decode_en    = ctrl.decode_en;
    assign exec_en      = ctrl.exec_en;
    assign mem_en       = ctrl.mem_en;
    assign fetch_flush  = ctrl.fetch_flush;
    assign decode_flush = ctrl.decode_flush;
    assign halt         = halt_q;
    assign stall_cnt    = stall_q;

endmodule
